// File: rtl/counter_credit_arbiter.sv
// Credit pool controller: arbitrates two requesters onto an external counter's
// decrement port, clamps returns onto its increment port and sequences reloads.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | counter reinit strobe, pool loaded with max; one cycle only
// RUN      | normal grant/return operation, accepts cfg_load
// QUIESCE  | no grants; waits until every credit is home, then reloads
module counter_credit_arbiter #(
   parameter int WIDTH         = 4,
   parameter int AMT_W         = 2,
   parameter int RESET_CREDITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req,
   input  logic [AMT_W-1:0] req_amt0,
   input  logic [AMT_W-1:0] req_amt1,
   output logic [1:0]       gnt,
   input  logic             ret_valid,
   input  logic [AMT_W-1:0] ret_amt,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] cfg_credits,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_reinit,
   output logic [WIDTH-1:0] cnt_initial_value,
   output logic             cnt_incr_valid,
   output logic [AMT_W-1:0] cnt_incr,
   output logic             cnt_decr_valid,
   output logic [AMT_W-1:0] cnt_decr,
   output logic             busy,
   output logic             ovf_err
);

   localparam logic [1:0] ST_INIT    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_QUIESCE = 2'd2;

   localparam int EW = WIDTH + 1;
   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_CREDITS);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_max;
   logic [WIDTH-1:0] r_pend;
   logic             r_rr_ptr;
   logic             r_ovf_err;

   logic             w_in_init;
   logic             w_in_run;
   logic             w_in_quiesce;
   logic             w_elig0;
   logic             w_elig1;
   logic             w_pick0;
   logic             w_pick1;
   logic [EW-1:0]    w_cnt_ext;
   logic [EW-1:0]    w_avail;
   logic [EW-1:0]    w_headroom;
   logic [EW-1:0]    w_ret_ext;
   logic             w_ret_over;
   logic             w_pool_home;

   assign w_in_init    = (r_state == ST_INIT);
   assign w_in_run     = (r_state == ST_RUN);
   assign w_in_quiesce = (r_state == ST_QUIESCE);
   assign w_cnt_ext    = EW'(cnt_value);
   assign w_pool_home  = (cnt_value == r_max);

   // Eligibility looks only at the registered pool value, so a grant can
   // never be funded by a return arriving in the same cycle.
   assign w_elig0 = w_in_run && req[0] && (req_amt0 != '0) && (EW'(req_amt0) <= w_cnt_ext);
   assign w_elig1 = w_in_run && req[1] && (req_amt1 != '0) && (EW'(req_amt1) <= w_cnt_ext);

   assign w_pick0 = w_elig0 && (!w_elig1 || !r_rr_ptr);
   assign w_pick1 = w_elig1 && (!w_elig0 ||  r_rr_ptr);

   assign gnt            = {w_pick1, w_pick0};
   assign cnt_decr_valid = w_pick0 || w_pick1;

   always_comb begin
      cnt_decr = '0;
      if (w_pick0) begin
         cnt_decr = req_amt0;
      end else if (w_pick1) begin
         cnt_decr = req_amt1;
      end
   end

   // Headroom counts the credits leaving this cycle as already gone, and
   // saturates at zero should the counter ever sit above the pool size.
   assign w_avail   = EW'(r_max) + EW'(cnt_decr);
   assign w_ret_ext = EW'(ret_amt);

   always_comb begin
      w_headroom = '0;
      if (w_avail > w_cnt_ext) begin
         w_headroom = w_avail - w_cnt_ext;
      end
   end

   always_comb begin
      cnt_incr   = '0;
      w_ret_over = 1'b0;
      if (ret_valid) begin
         if (w_in_init) begin
            w_ret_over = 1'b1;
         end else if (w_ret_ext > w_headroom) begin
            cnt_incr   = w_headroom[AMT_W-1:0];
            w_ret_over = 1'b1;
         end else begin
            cnt_incr = ret_amt;
         end
      end
   end

   assign cnt_incr_valid    = (cnt_incr != '0);
   assign cnt_reinit        = w_in_init;
   assign cnt_initial_value = r_max;
   assign busy              = !w_in_run;
   assign ovf_err           = r_ovf_err;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (cfg_load) begin
               w_state_nxt = ST_QUIESCE;
            end
         end
         ST_QUIESCE: begin
            if (w_pool_home) begin
               w_state_nxt = ST_INIT;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_INIT;
         r_max     <= RESET_VAL;
         r_pend    <= RESET_VAL;
         r_rr_ptr  <= 1'b0;
         r_ovf_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pick0 || w_pick1) begin
            r_rr_ptr <= w_pick0;
         end
         if (w_in_run && cfg_load) begin
            r_pend <= cfg_credits;
         end
         if (w_in_quiesce && w_pool_home) begin
            r_max <= r_pend;
         end
         if (w_ret_over) begin
            r_ovf_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_credit_arbiter.sv
// Bench for counter_credit_arbiter: models the external credit counter, runs
// a pool-level reference model every cycle and adds directed literal checks.
module tb_counter_credit_arbiter;

   localparam int WIDTH = 4;
   localparam int AMT_W = 2;

   logic             clk;
   logic             rst;
   logic [1:0]       req;
   logic [AMT_W-1:0] req_amt0;
   logic [AMT_W-1:0] req_amt1;
   logic [1:0]       gnt;
   logic             ret_valid;
   logic [AMT_W-1:0] ret_amt;
   logic             cfg_load;
   logic [WIDTH-1:0] cfg_credits;
   logic [WIDTH-1:0] cnt_value;
   logic             cnt_reinit;
   logic [WIDTH-1:0] cnt_initial_value;
   logic             cnt_incr_valid;
   logic [AMT_W-1:0] cnt_incr;
   logic             cnt_decr_valid;
   logic [AMT_W-1:0] cnt_decr;
   logic             busy;
   logic             ovf_err;

   int n_tests = 0;
   int n_fail  = 0;

   counter_credit_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .RESET_CREDITS(8)) dut (
      .clk(clk), .rst(rst), .req(req), .req_amt0(req_amt0), .req_amt1(req_amt1),
      .gnt(gnt), .ret_valid(ret_valid), .ret_amt(ret_amt), .cfg_load(cfg_load),
      .cfg_credits(cfg_credits), .cnt_value(cnt_value), .cnt_reinit(cnt_reinit),
      .cnt_initial_value(cnt_initial_value), .cnt_incr_valid(cnt_incr_valid),
      .cnt_incr(cnt_incr), .cnt_decr_valid(cnt_decr_valid), .cnt_decr(cnt_decr),
      .busy(busy), .ovf_err(ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The shared counter the arbiter drives.
   always @(posedge clk) begin
      if (rst)
         cnt_value <= '0;
      else if (cnt_reinit)
         cnt_value <= cnt_initial_value;
      else
         cnt_value <= cnt_value + (cnt_incr_valid ? WIDTH'(cnt_incr) : '0)
                                - (cnt_decr_valid ? WIDTH'(cnt_decr) : '0);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: mode 0=reload, 1=running, 2=draining.
   int m_mode, m_pool, m_pend, m_turn, m_ovf;
   bit m_valid = 1'b0;

   always @(negedge clk) begin
      int a0, a1, c, win, dec, room, inc;
      bit e0, e1, over;
      a0 = int'(req_amt0);
      a1 = int'(req_amt1);
      c  = int'(cnt_value);
      e0 = (m_mode == 1) && req[0] && a0 > 0 && a0 <= c;
      e1 = (m_mode == 1) && req[1] && a1 > 0 && a1 <= c;
      win = -1;
      if (e0 && e1) win = m_turn;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      dec  = (win == 0) ? a0 : (win == 1) ? a1 : 0;
      room = m_pool - c + dec;
      if (room < 0) room = 0;
      inc = 0;
      if (ret_valid && m_mode != 0) inc = (int'(ret_amt) < room) ? int'(ret_amt) : room;
      over = ret_valid && (m_mode == 0 || int'(ret_amt) > room);
      if (m_valid) begin
         chk("gnt",        int'(gnt), (win < 0) ? 0 : (1 << win));
         chk("decr_valid", int'(cnt_decr_valid), int'(win >= 0));
         chk("decr",       int'(cnt_decr), dec);
         chk("incr",       int'(cnt_incr), inc);
         chk("incr_valid", int'(cnt_incr_valid), int'(inc != 0));
         chk("reinit",     int'(cnt_reinit), int'(m_mode == 0));
         chk("init_value", int'(cnt_initial_value), m_pool);
         chk("busy",       int'(busy), int'(m_mode != 1));
         chk("ovf_err",    int'(ovf_err), m_ovf);
      end
      if (rst) begin
         m_mode = 0; m_pool = 8; m_pend = 8; m_turn = 0; m_ovf = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         if (win >= 0) m_turn = 1 - win;
         if (over) m_ovf = 1;
         case (m_mode)
            0: m_mode = 1;
            1: if (cfg_load) begin m_pend = int'(cfg_credits); m_mode = 2; end
            default: if (c == m_pool) begin m_pool = m_pend; m_mode = 0; end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   int exp_cnt[5] = '{8, 6, 4, 2, 0};
   int exp_gnt[5] = '{1, 2, 1, 2, 0};

   initial begin
      rst = 1'b1; req = '0; req_amt0 = '0; req_amt1 = '0;
      ret_valid = 1'b0; ret_amt = '0; cfg_load = 1'b0; cfg_credits = '0;
      repeat (3) step();

      // Reset release: one INIT cycle, then RUN with a full pool.
      rst = 1'b0;
      sample();
      chk("rst_reinit", int'(cnt_reinit), 1);
      chk("rst_busy", int'(busy), 1);
      chk("rst_initval", int'(cnt_initial_value), 8);

      // Contention: both ask for 2 and hold.
      step();
      req = 2'b11; req_amt0 = 2'd2; req_amt1 = 2'd2;
      sample();
      chk("run_busy", int'(busy), 0);
      chk("run_reinit", int'(cnt_reinit), 0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         if (k > 0) sample();
         chk("cont_cnt", int'(cnt_value), exp_cnt[k]);
         chk("cont_gnt", int'(gnt), exp_gnt[k]);
      end

      // Insufficient credit: pool 1, req0 wants 2, req1 wants 1.
      step();
      req = '0; ret_valid = 1'b1; ret_amt = 2'd1;
      sample();
      chk("ret1_incr", int'(cnt_incr), 1);
      step();
      ret_valid = 1'b0; req = 2'b11; req_amt0 = 2'd2; req_amt1 = 2'd1;
      sample();
      chk("insuf_cnt", int'(cnt_value), 1);
      chk("insuf_gnt", int'(gnt), 2);
      step();
      req = '0;
      sample();
      chk("insuf_after", int'(cnt_value), 0);

      // Overflow clamp: fill to 7, then return 3.
      step(); ret_valid = 1'b1; ret_amt = 2'd3;
      step(); ret_amt = 2'd3;
      step(); ret_amt = 2'd1;
      step(); ret_amt = 2'd3;
      sample();
      chk("ovf_cnt7", int'(cnt_value), 7);
      chk("ovf_incr", int'(cnt_incr), 1);
      step();
      ret_valid = 1'b0; req = 2'b01; req_amt0 = 2'd0;
      sample();
      chk("ovf_cnt8", int'(cnt_value), 8);
      chk("ovf_flag", int'(ovf_err), 1);
      chk("zero_amt_gnt", int'(gnt), 0);

      // Fresh reset, then simultaneous grant and return at a full pool.
      step(); req = '0; rst = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      req = 2'b01; req_amt0 = 2'd2; ret_valid = 1'b1; ret_amt = 2'd2;
      sample();
      chk("sim_gnt", int'(gnt), 1);
      chk("sim_decr", int'(cnt_decr), 2);
      chk("sim_incr", int'(cnt_incr), 2);
      step();
      ret_valid = 1'b0; req_amt0 = 2'd3;
      sample();
      chk("sim_cnt", int'(cnt_value), 8);
      chk("sim_ovf", int'(ovf_err), 0);
      chk("sim_gnt2", int'(gnt), 1);

      // Reconfigure to 12 at pool 5.
      step();
      req = '0; cfg_load = 1'b1; cfg_credits = 4'd12;
      sample();
      chk("cfg_cnt5", int'(cnt_value), 5);
      step();
      cfg_load = 1'b0; req = 2'b01; req_amt0 = 2'd1;
      sample();
      chk("q_busy", int'(busy), 1);
      chk("q_gnt", int'(gnt), 0);
      step();
      ret_valid = 1'b1; ret_amt = 2'd3;
      sample();
      chk("q_gnt2", int'(gnt), 0);
      chk("q_incr", int'(cnt_incr), 3);
      step();
      ret_valid = 1'b0;
      sample();
      chk("q_home", int'(cnt_value), 8);
      step();
      sample();
      chk("re_reinit", int'(cnt_reinit), 1);
      chk("re_initval", int'(cnt_initial_value), 12);
      chk("re_gnt", int'(gnt), 0);
      step();
      req = '0;
      sample();
      chk("re_cnt12", int'(cnt_value), 12);
      chk("re_busy", int'(busy), 0);

      // Minimum reload latency with a full pool: 12 -> 5.
      step();
      cfg_load = 1'b1; cfg_credits = 4'd5;
      sample();
      step();
      cfg_load = 1'b0;
      sample();
      chk("min_busy", int'(busy), 1);
      step();
      sample();
      chk("min_initval", int'(cnt_initial_value), 5);
      step();
      sample();
      chk("min_cnt5", int'(cnt_value), 5);
      chk("min_busy0", int'(busy), 0);

      // Return during INIT is dropped and flagged.
      step(); rst = 1'b1;
      step();
      rst = 1'b0; ret_valid = 1'b1; ret_amt = 2'd1;
      sample();
      chk("init_ret_incr", int'(cnt_incr_valid), 0);
      step();
      ret_valid = 1'b0;
      sample();
      chk("init_ret_ovf", int'(ovf_err), 1);
      chk("init_ret_cnt", int'(cnt_value), 8);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
